// File: rtl/power_state_reg.sv
// power_state_reg: car power flag (long-press on, button/fault/idle off) and registered car/moving state.
module power_state_reg #(
  parameter int ON_HOLD_CYC = 100_000_000,
  parameter int IDLE_CYC    = 1_000_000_000,
  parameter int WARN_CYC    = 300_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on_btn,
  input  logic       power_off_btn,
  input  logic [1:0] global_state,
  input  logic       manual_power,
  input  logic [1:0] next_state,
  input  logic [3:0] next_moving_state,
  output logic       power,
  output logic [1:0] state,
  output logic [3:0] moving_state,
  output logic       idle_warn
);
  localparam int HW = ON_HOLD_CYC > 1 ? $clog2(ON_HOLD_CYC) : 1;
  localparam int IW = IDLE_CYC > 1 ? $clog2(IDLE_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ON_HOLD_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [IW-1:0] WARN_AT   = IW'(IDLE_CYC - WARN_CYC);
  localparam logic [1:0] NSTART = 2'b00, START = 2'b01, MOVING = 2'b10;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} pwr_e;
  pwr_e pwr_q, pwr_d;
  logic on_s1_q, on_s_q, off_s1_q, off_s_q, off_d_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idle_q, idle_d;
  logic warn_q, warn_d;
  logic [1:0] state_q, state_d;
  logic [3:0] mov_q, mov_d;
  logic off_edge, fault, idle_ok, auto_off, hold_done, kill, bad_mov;
  always_comb begin
    off_edge  = off_s_q & ~off_d_q;
    fault     = global_state == 2'b00 && !manual_power;
    idle_ok   = pwr_q == ON && global_state == 2'b00 && state_q == NSTART && !on_s_q && !off_s_q;
    auto_off  = pwr_q == ON && idle_q == IDLE_LAST;
    hold_done = pwr_q == OFF && on_s_q && hold_q == HOLD_LAST;
    pwr_d     = pwr_q == OFF ? (hold_done ? ON : OFF) : ((off_edge || fault || auto_off) ? OFF : ON);
    hold_d    = (pwr_q == OFF && on_s_q && !hold_done) ? hold_q + HW'(1) : '0;
    idle_d    = (idle_ok && !auto_off) ? idle_q + IW'(1) : '0;
    warn_d    = pwr_d == ON && idle_d >= WARN_AT;
    // An unpowered car, a non-manual mode or an illegal decoder state parks the car.
    kill      = pwr_d == OFF || global_state != 2'b00 || next_state == 2'b11;
    bad_mov   = next_state == MOVING && !$onehot(next_moving_state);
    state_d   = kill ? NSTART : (bad_mov ? START : next_state);
    mov_d     = (kill || bad_mov) ? 4'b0000 : next_moving_state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwr_q    <= OFF;
      on_s1_q  <= 1'b0;
      on_s_q   <= 1'b0;
      off_s1_q <= 1'b0;
      off_s_q  <= 1'b0;
      off_d_q  <= 1'b0;
      hold_q   <= '0;
      idle_q   <= '0;
      warn_q   <= 1'b0;
      state_q  <= NSTART;
      mov_q    <= 4'b0000;
    end else begin
      pwr_q    <= pwr_d;
      on_s1_q  <= power_on_btn;
      on_s_q   <= on_s1_q;
      off_s1_q <= power_off_btn;
      off_s_q  <= off_s1_q;
      off_d_q  <= off_s_q;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      warn_q   <= warn_d;
      state_q  <= state_d;
      mov_q    <= mov_d;
    end
  end
  assign power        = pwr_q == ON;
  assign state        = state_q;
  assign moving_state = mov_q;
  assign idle_warn    = warn_q;
endmodule

// File: tb/tb_power_state_reg.sv
// tb_power_state_reg: directed checks of power_state_reg; observed word is {power, state, moving_state, idle_warn}.
module tb_power_state_reg;
  logic clk = 1'b0, rst = 1'b1, power_on_btn = 1'b0, power_off_btn = 1'b0, manual_power = 1'b1;
  logic [1:0] global_state = 2'b00, next_state = 2'b00;
  logic [3:0] next_moving_state = 4'b0000;
  logic power, idle_warn;
  logic [1:0] state;
  logic [3:0] moving_state;
  int tests = 0, fails = 0;
  power_state_reg #(.ON_HOLD_CYC(4), .IDLE_CYC(16), .WARN_CYC(4)) dut (
    .clk(clk), .rst(rst), .power_on_btn(power_on_btn), .power_off_btn(power_off_btn),
    .global_state(global_state), .manual_power(manual_power), .next_state(next_state),
    .next_moving_state(next_moving_state), .power(power), .state(state),
    .moving_state(moving_state), .idle_warn(idle_warn)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] obs();
    return {power, state, moving_state, idle_warn};
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b0; power_on_btn = 1'b0; power_off_btn = 1'b0; global_state = 2'b00;
    manual_power = 1'b1; next_state = 2'b00; next_moving_state = 4'b0000;
    step(2);
    rst = 1'b1;
  endtask
  // Six edges of press give power; two more edges let on_s drop so the idle count starts at 0.
  task automatic power_up();
    power_on_btn = 1'b1;
    step(6);
    power_on_btn = 1'b0;
    step(2);
  endtask
  task automatic test_reset();
    rst = 1'b0; power_on_btn = 1'b1; power_off_btn = 1'b1;
    step(2);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL reset_state got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    rst = 1'b1; power_off_btn = 1'b0;
    step(5);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL reset_release_early got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL reset_release_on got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
  endtask
  task automatic test_power_on_hold();
    do_reset();
    power_on_btn = 1'b1;
    step(3);
    power_on_btn = 1'b0;
    step(1);
    power_on_btn = 1'b1;
    step(5);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL hold_restart got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL hold_power_on got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    power_on_btn = 1'b0;
  endtask
  task automatic test_state_tracking();
    do_reset();
    power_up();
    next_state = 2'b10; next_moving_state = 4'b0001;
    #1;
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL track_latency got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_10_0001_0) begin fails++; $display("FAIL track_fwd got=%b exp=%b", obs(), 8'b1_10_0001_0); end
    tests++;
    next_moving_state = 4'b0100;
    step(1);
    if (obs() !== 8'b1_10_0100_0) begin fails++; $display("FAIL track_left got=%b exp=%b", obs(), 8'b1_10_0100_0); end
    tests++;
    next_moving_state = 4'b0011;
    step(1);
    if (obs() !== 8'b1_01_0000_0) begin fails++; $display("FAIL track_not_onehot got=%b exp=%b", obs(), 8'b1_01_0000_0); end
    tests++;
    next_moving_state = 4'b1000;
    step(1);
    if (obs() !== 8'b1_10_1000_0) begin fails++; $display("FAIL track_right got=%b exp=%b", obs(), 8'b1_10_1000_0); end
    tests++;
    next_moving_state = 4'b0000;
    step(1);
    if (obs() !== 8'b1_01_0000_0) begin fails++; $display("FAIL track_moving_zero got=%b exp=%b", obs(), 8'b1_01_0000_0); end
    tests++;
    next_state = 2'b11; next_moving_state = 4'b0100;
    step(1);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL track_illegal got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    next_state = 2'b00; next_moving_state = 4'b0000;
  endtask
  task automatic test_fault();
    do_reset();
    power_up();
    next_state = 2'b10; next_moving_state = 4'b0010;
    step(1);
    if (obs() !== 8'b1_10_0010_0) begin fails++; $display("FAIL fault_moving got=%b exp=%b", obs(), 8'b1_10_0010_0); end
    tests++;
    manual_power = 1'b0;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL fault_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    manual_power = 1'b1;
    step(3);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL fault_stays_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    next_state = 2'b00; next_moving_state = 4'b0000;
  endtask
  task automatic test_idle();
    do_reset();
    power_up();
    step(11);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL idle_11_no_warn got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_00_0000_1) begin fails++; $display("FAIL idle_12_warn got=%b exp=%b", obs(), 8'b1_00_0000_1); end
    tests++;
    step(3);
    if (obs() !== 8'b1_00_0000_1) begin fails++; $display("FAIL idle_15_on got=%b exp=%b", obs(), 8'b1_00_0000_1); end
    tests++;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL idle_auto_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    step(2);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL idle_stays_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    do_reset();
    power_up();
    step(10);
    next_state = 2'b01;
    step(1);
    if (obs() !== 8'b1_01_0000_0) begin fails++; $display("FAIL idle_start_insert got=%b exp=%b", obs(), 8'b1_01_0000_0); end
    tests++;
    next_state = 2'b00;
    step(12);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL idle_restart_11 got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_00_0000_1) begin fails++; $display("FAIL idle_restart_warn got=%b exp=%b", obs(), 8'b1_00_0000_1); end
    tests++;
    step(3);
    if (obs() !== 8'b1_00_0000_1) begin fails++; $display("FAIL idle_restart_15 got=%b exp=%b", obs(), 8'b1_00_0000_1); end
    tests++;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL idle_restart_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
  endtask
  task automatic test_off_button();
    do_reset();
    power_up();
    power_off_btn = 1'b1;
    step(2);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL off_latency got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL off_third_edge got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    step(17);
    power_up();
    step(5);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL off_held_single_event got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    power_off_btn = 1'b0;
    step(3);
    power_off_btn = 1'b1;
    step(2);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL off_repress_wait got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL off_repress got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    power_off_btn = 1'b0;
    do_reset();
    power_up();
    global_state = 2'b01; manual_power = 1'b0; next_state = 2'b10; next_moving_state = 4'b0001;
    step(3);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL mode_no_fault got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    global_state = 2'b00; manual_power = 1'b1; next_state = 2'b00; next_moving_state = 4'b0000;
  endtask
  task automatic test_back_to_back();
    do_reset();
    power_on_btn = 1'b1; power_off_btn = 1'b1;
    step(5);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL b2b_off_in_off got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    step(1);
    if (obs() !== 8'b1_00_0000_0) begin fails++; $display("FAIL b2b_on_despite_off got=%b exp=%b", obs(), 8'b1_00_0000_0); end
    tests++;
    power_on_btn = 1'b0; power_off_btn = 1'b0;
    step(3);
    power_off_btn = 1'b1;
    step(2);
    manual_power = 1'b0;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL b2b_off_and_fault got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    do_reset();
    power_up();
    next_state = 2'b10; next_moving_state = 4'b0010;
    step(1);
    rst = 1'b0;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL b2b_mid_reset got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
    rst = 1'b1;
    step(1);
    if (obs() !== 8'b0_00_0000_0) begin fails++; $display("FAIL b2b_after_reset got=%b exp=%b", obs(), 8'b0_00_0000_0); end
    tests++;
  endtask
  initial begin
    test_reset();
    test_power_on_hold();
    test_state_tracking();
    test_fault();
    test_idle();
    test_off_button();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/power_state_reg.md
# power_state_reg

Power-control and state-register stage directly downstream of the manual-driving decoder. It owns the car's `power` flag (long-press power-on, immediate power-off, fault shutdown from the decoder's `manual_power`, idle auto-off) and registers the decoder's combinational `next_state` and `next_moving_state` into the `state` and `moving_state` values that are fed back to that decoder. It also drives an idle-warning indicator.

## Interface
- `ON_HOLD_CYC`, 100_000_000: cycles `power_on_btn` must be held to power on (1 s at 100 MHz).
- `IDLE_CYC`, 1_000_000_000: cycles of continuous NSTART idle before auto-off (10 s).
- `WARN_CYC`, 300_000_000: length of the idle-warning window before auto-off.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, **active-low**.
- `power_on_btn` in 1: raw power-on button; asynchronous.
- `power_off_btn` in 1: raw power-off button; asynchronous.
- `global_state` in 2: mode select; 2'b00 = manual.
- `manual_power` in 1: decoder's power request; 0 = fault shutdown.
- `next_state` in 2: decoder's next car state.
- `next_moving_state` in 4: decoder's next moving state.
- `power` out 1: car powered.
- `state` out 2: registered car state (NSTART 00, START 01, MOVING 10).
- `moving_state` out 4: registered moving state (0000 none, 0001 fwd, 0010 back, 0100 left, 1000 right).
- `idle_warn` out 1: auto-off imminent.

## Operation
- Both buttons pass through a 2-flop synchronizer, giving `on_s` and `off_s`. `off_s` also feeds a delay flop `off_d`. `off_edge = off_s & ~off_d`.
- `power` FSM, two states: OFF (0) and ON (1).
- OFF → ON:
  - `hold_cnt` increments each cycle `on_s = 1`. It clears to 0 when `on_s = 0` or when `power = 1`.
  - When `hold_cnt == ON_HOLD_CYC-1` and `on_s = 1`, `power` becomes 1 at the next edge.
- ON → OFF. Priority, highest first, evaluated each cycle:
  1. `off_edge`.
  2. `global_state == 00 && manual_power == 0` (fault).
  3. `idle_cnt == IDLE_CYC-1` (auto-off).
- Buttons are ignored when already in the target state: `off_edge` in OFF, `on_s` in ON.
- Idle counter:
  - `idle_cnt` increments while `power = 1`, `global_state == 00`, `state == NSTART`, `on_s = 0` and `off_s = 0`. Otherwise it clears to 0.
  - It also clears on auto-off.
- `idle_warn` = `power && idle_cnt >= IDLE_CYC-WARN_CYC`. This output is registered.
- State register update each edge:
  - `state` ← NSTART and `moving_state` ← 0000 if any of these hold: `power` is 0 after this edge; `global_state != 00`; `next_state == 2'b11` (illegal).
  - Otherwise `state` ← `next_state` and `moving_state` ← `next_moving_state`.
  - A `next_moving_state` that is not one-hot, or is 0000, while `next_state` is MOVING, registers as 0000 with `state` = START.
- All counters saturate-free. Width = `$clog2` of the parameter. Counters never exceed their terminal value.

## Timing
- Reset (`rst = 0` at an edge): `power` = 0, `state` = 00, `moving_state` = 0000, `idle_warn` = 0. `hold_cnt`, `idle_cnt`, and the sync/delay flops all clear. This applies mid-operation too; reset overrides everything.
- Power-off latency: raw `power_off_btn` rising before edge k gives `power` = 0 after edge k+2. `state` is NSTART after the same edge.
- Fault shutdown: `manual_power` = 0 sampled at edge k gives `power` = 0, `state` = NSTART, `moving_state` = 0000 after edge k. This is a one-cycle response.
- Power-on: `power` = 1 after the edge where `hold_cnt` reaches `ON_HOLD_CYC-1` with `on_s` high. That is `ON_HOLD_CYC`+2 edges after the raw press. Releasing for one cycle restarts the count.
- Auto-off: `power` falls on the edge where `idle_cnt == IDLE_CYC-1` is sampled. `idle_warn` falls on the same edge.
- Simultaneous events:
  - `off_edge` and fault together: power off (same result).
  - `off_edge` while `hold_cnt` counting in OFF: no effect.
  - Holding `power_off_btn` gives only one off event. A re-press is needed.
- Register path latency `next_*` → outputs: one edge.

## Test plan
Use `ON_HOLD_CYC=4`, `IDLE_CYC=16`, `WARN_CYC=4`.
- **Reset.** Drive `rst=0` for 2 cycles with buttons high → `power=0`, `state=00`, `moving_state=0000`, `idle_warn=0`. Release → still 0 until a full hold.
- **Power-on hold.** Hold `power_on_btn` for 3 cycles, release, then hold 6 → `power` stays 0 after the first hold. It rises exactly 6 edges (4+2) after the second press.
- **State tracking.** With `power=1`, `global_state=00`, `manual_power=1`, drive `next_state=10`, `next_moving_state=0100` → registered `10`/`0100` one edge later. Drive `next_state=11` → `00`/`0000`.
- **Fault shutdown.** In MOVING with `manual_power=0` for one cycle → `power=0`, `state=00`, `moving_state=0000` after 1 edge. A later `manual_power=1` does not restore power.
- **Idle auto-off.** Hold `next_state=00`, no buttons → `idle_warn=1` from `idle_cnt=12`, then `power=0` at `idle_cnt=15`. Insert `next_state=01` at count 10 → counter restarts from 0.
- **Off button and mode.** Hold `power_off_btn` high for 20 cycles → `power=0` 3 edges after the press, with a single event. Separately, with `global_state=01` and `manual_power=0` → `power` stays 1 and `state` is forced `00`.
